// File: rtl/kgp_isa_pkg.sv
// KGP_RISC ISA constants, field positions and the decoder control word.
// Shared by the decoder, the ID stage and anything that needs opcodes.
package kgp_isa_pkg;

    localparam int unsigned PC_W     = 8;
    localparam int unsigned LINK_REG = 31;

    localparam logic [5:0] OP_ALU  = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h01;
    localparam logic [5:0] OP_LD   = 6'h02;
    localparam logic [5:0] OP_ST   = 6'h03;
    localparam logic [5:0] OP_BR   = 6'h04;
    localparam logic [5:0] OP_BZ   = 6'h05;
    localparam logic [5:0] OP_BNZ  = 6'h06;
    localparam logic [5:0] OP_CALL = 6'h07;
    localparam logic [5:0] OP_RET  = 6'h08;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int IMM_HI = 15;

    typedef enum logic [1:0] {
        DST_NONE,
        DST_RD,
        DST_RT,
        DST_LINK
    } dest_sel_e;

    typedef enum logic [2:0] {
        BK_NONE,
        BK_BR,
        BK_BZ,
        BK_BNZ,
        BK_CALL,
        BK_RET
    } br_kind_e;

    typedef struct packed {
        logic      legal;
        logic      wr_en;
        logic      mem_rd;
        logic      mem_wr;
        logic      uses_rs;
        logic      uses_rt;
        dest_sel_e dest_sel;
        br_kind_e  br_kind;
    } ctrl_t;

endpackage

// File: rtl/kgp_decoder.sv
// Combinational opcode -> control word decoder.
// Ports: op (opcode in), ctrl (control word out; legal=0 for undefined).
module kgp_decoder
    import kgp_isa_pkg::*;
(
    input  logic [5:0] op,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl       = '0;
        ctrl.legal = 1'b1;
        unique case (op)
            OP_ALU: begin
                ctrl.wr_en    = 1'b1;
                ctrl.uses_rs  = 1'b1;
                ctrl.uses_rt  = 1'b1;
                ctrl.dest_sel = DST_RD;
            end
            OP_ADDI: begin
                ctrl.wr_en    = 1'b1;
                ctrl.uses_rs  = 1'b1;
                ctrl.dest_sel = DST_RT;
            end
            OP_LD: begin
                ctrl.wr_en    = 1'b1;
                ctrl.mem_rd   = 1'b1;
                ctrl.uses_rs  = 1'b1;
                ctrl.dest_sel = DST_RT;
            end
            OP_ST: begin
                ctrl.mem_wr  = 1'b1;
                ctrl.uses_rs = 1'b1;
                ctrl.uses_rt = 1'b1;
            end
            OP_BR:  ctrl.br_kind = BK_BR;
            OP_BZ: begin
                ctrl.uses_rs = 1'b1;
                ctrl.br_kind = BK_BZ;
            end
            OP_BNZ: begin
                ctrl.uses_rs = 1'b1;
                ctrl.br_kind = BK_BNZ;
            end
            OP_CALL: begin
                ctrl.wr_en    = 1'b1;
                ctrl.dest_sel = DST_LINK;
                ctrl.br_kind  = BK_CALL;
            end
            OP_RET: begin
                ctrl.uses_rs = 1'b1;
                ctrl.br_kind = BK_RET;
            end
            default: ctrl.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/id_redirect_stage.sv
// KGP_RISC decode stage: ID/EX register, branch/CALL/RET redirect,
// load-use and branch-dependency stall, one-slot squash after a redirect.
// Ports: clock1/rst (sync active-low); IF/ID in (instruction, NPC,
// if_valid); rs_data/rs_addr/rt_addr to the regfile; select/EN/stall to
// fetch; id_* ID/EX register outputs; illegal sticky undefined-opcode flag.
module id_redirect_stage
    import kgp_isa_pkg::*;
#(
    parameter int unsigned P_PC_W     = PC_W,
    parameter int unsigned P_LINK_REG = LINK_REG
) (
    input  logic              clock1,
    input  logic              rst,
    input  logic [31:0]       instruction,
    input  logic [P_PC_W-1:0] NPC,
    input  logic              if_valid,
    input  logic [31:0]       rs_data,
    output logic [4:0]        rs_addr,
    output logic [4:0]        rt_addr,
    output logic              select,
    output logic [P_PC_W-1:0] EN,
    output logic              stall,
    output logic              id_valid,
    output logic [5:0]        id_opcode,
    output logic [4:0]        id_rs,
    output logic [4:0]        id_rt,
    output logic [4:0]        id_dest,
    output logic [31:0]       id_imm,
    output logic [P_PC_W-1:0] id_npc,
    output logic              id_wr_en,
    output logic              id_mem_rd,
    output logic              id_mem_wr,
    output logic              illegal
);

    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        dest;
    logic [P_PC_W-1:0] target;
    ctrl_t             c;
    logic              squash_q;
    logic              cur;
    logic              dep_rs;
    logic              dep_rt;
    logic              hazard;
    logic              taken;
    logic              rs_zero;

    assign opcode  = instruction[OPC_HI:OPC_LO];
    assign rs      = instruction[RS_HI:RS_LO];
    assign rt      = instruction[RT_HI:RT_LO];
    assign rd      = instruction[RD_HI:RD_LO];
    assign rs_addr = rs;
    assign rt_addr = rt;
    assign rs_zero = ~|rs_data;

    kgp_decoder u_dec (
        .op  (opcode),
        .ctrl(c)
    );

    always_comb begin
        dest = '0;
        unique case (c.dest_sel)
            DST_RD:   dest = rd;
            DST_RT:   dest = rt;
            DST_LINK: dest = 5'(P_LINK_REG);
            default:  dest = '0;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        unique case (c.br_kind)
            BK_BR, BK_CALL, BK_RET: taken = 1'b1;
            BK_BZ:                  taken = rs_zero;
            BK_BNZ:                 taken = ~rs_zero;
            default:                taken = 1'b0;
        endcase
    end

    assign target = (c.br_kind == BK_RET) ? rs_data[P_PC_W-1:0]
                                          : instruction[P_PC_W-1:0];

    assign cur    = if_valid & ~squash_q;
    assign dep_rs = c.uses_rs & (id_dest == rs);
    assign dep_rt = c.uses_rt & (id_dest == rt);

    // Only branches consuming rs in ID and load-use need a stall;
    // ALU results are forwarded downstream.
    always_comb begin
        hazard = 1'b0;
        if (cur && id_valid && id_wr_en && (id_dest != 5'd0)) begin
            if ((c.br_kind == BK_BZ || c.br_kind == BK_BNZ ||
                 c.br_kind == BK_RET) && dep_rs)
                hazard = 1'b1;
            if (id_mem_rd && (dep_rs || dep_rt))
                hazard = 1'b1;
        end
    end

    assign stall  = rst & hazard;
    assign select = rst & cur & ~hazard & taken;
    assign EN     = select ? target : '0;

    always_ff @(posedge clock1) begin
        if (!rst) begin
            squash_q  <= 1'b0;
            illegal   <= 1'b0;
            id_valid  <= 1'b0;
            id_opcode <= '0;
            id_rs     <= '0;
            id_rt     <= '0;
            id_dest   <= '0;
            id_imm    <= '0;
            id_npc    <= '0;
            id_wr_en  <= 1'b0;
            id_mem_rd <= 1'b0;
            id_mem_wr <= 1'b0;
        end else if (squash_q || hazard) begin
            squash_q  <= 1'b0;
            id_valid  <= 1'b0;
            id_opcode <= '0;
            id_rs     <= '0;
            id_rt     <= '0;
            id_dest   <= '0;
            id_imm    <= '0;
            id_npc    <= '0;
            id_wr_en  <= 1'b0;
            id_mem_rd <= 1'b0;
            id_mem_wr <= 1'b0;
        end else begin
            squash_q  <= select;
            illegal   <= illegal | (cur & ~c.legal);
            id_valid  <= cur;
            id_opcode <= opcode;
            id_rs     <= rs;
            id_rt     <= rt;
            id_dest   <= dest;
            id_imm    <= {{16{instruction[IMM_HI]}}, instruction[IMM_HI:0]};
            id_npc    <= NPC;
            id_wr_en  <= c.wr_en;
            id_mem_rd <= c.mem_rd;
            id_mem_wr <= c.mem_wr;
        end
    end

endmodule

// File: tb/tb_id_redirect_stage.sv
// Randomized + directed bench for id_redirect_stage against a
// behavioural pipeline model.
module tb_id_redirect_stage;
    import kgp_isa_pkg::*;

    logic        clock1 = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instruction = '0;
    logic [7:0]  NPC = '0;
    logic        if_valid = 1'b0;
    logic [31:0] rs_data = '0;
    logic [4:0]  rs_addr, rt_addr;
    logic        select, stall, id_valid, illegal;
    logic [7:0]  EN, id_npc;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs, id_rt, id_dest;
    logic [31:0] id_imm;
    logic        id_wr_en, id_mem_rd, id_mem_wr;

    int errors = 0;
    int checks = 0;

    always #5 clock1 = ~clock1;

    id_redirect_stage dut (
        .clock1(clock1), .rst(rst), .instruction(instruction), .NPC(NPC),
        .if_valid(if_valid), .rs_data(rs_data), .rs_addr(rs_addr),
        .rt_addr(rt_addr), .select(select), .EN(EN), .stall(stall),
        .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs),
        .id_rt(id_rt), .id_dest(id_dest), .id_imm(id_imm), .id_npc(id_npc),
        .id_wr_en(id_wr_en), .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr),
        .illegal(illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Model state: what the ID/EX latch should hold.
    logic        m_valid, m_wr, m_rd, m_wm, m_sq, m_ill;
    logic [5:0]  m_op;
    logic [4:0]  m_rs, m_rt, m_dest;
    logic [31:0] m_imm;
    logic [7:0]  m_npc;
    logic        s_sel, s_stall;
    logic [7:0]  s_en;

    function automatic logic [31:0] mk(logic [5:0] op, logic [4:0] a,
                                       logic [4:0] b, logic [15:0] imm);
        return {op, a, b, imm};
    endfunction

    function automatic bit known(logic [5:0] op);
        return op <= OP_RET;
    endfunction

    function automatic bit writes(logic [5:0] op);
        return op == OP_ALU || op == OP_ADDI || op == OP_LD || op == OP_CALL;
    endfunction

    function automatic logic [4:0] dest_of(logic [31:0] ins);
        case (ins[31:26])
            OP_ALU:         return ins[15:11];
            OP_ADDI, OP_LD: return ins[20:16];
            OP_CALL:        return 5'd31;
            default:        return 5'd0;
        endcase
    endfunction

    function automatic bit reads_rs(logic [5:0] op);
        return op == OP_ALU || op == OP_ADDI || op == OP_LD || op == OP_ST ||
               op == OP_BZ || op == OP_BNZ || op == OP_RET;
    endfunction

    function automatic bit reads_rt(logic [5:0] op);
        return op == OP_ALU || op == OP_ST;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_wr = 0; m_rd = 0; m_wm = 0; m_sq = 0; m_ill = 0;
        m_op = 0; m_rs = 0; m_rt = 0; m_dest = 0; m_imm = 0; m_npc = 0;
    endtask

    task automatic step(input logic [31:0] ins, input logic [7:0] npc,
                        input logic v, input logic [31:0] rsd,
                        input logic r);
        logic [5:0] op;
        logic       cur, haz, tk, e_sel;
        logic [7:0] e_en;
        bit         d_rs, d_rt;
        @(negedge clock1);
        instruction = ins; NPC = npc; if_valid = v; rs_data = rsd; rst = r;
        #1;
        op   = ins[31:26];
        cur  = v && !m_sq;
        d_rs = reads_rs(op) && m_dest == ins[25:21];
        d_rt = reads_rt(op) && m_dest == ins[20:16];
        haz  = cur && m_valid && m_wr && m_dest != 0 &&
               (((op == OP_BZ || op == OP_BNZ || op == OP_RET) && d_rs) ||
                (m_rd && (d_rs || d_rt)));
        tk   = op == OP_BR || op == OP_CALL || op == OP_RET ||
               (op == OP_BZ && rsd == 0) || (op == OP_BNZ && rsd != 0);
        e_sel = r && cur && !haz && tk;
        e_en  = !e_sel ? 8'h00 : (op == OP_RET) ? rsd[7:0] : ins[7:0];
        check("select", select, e_sel);
        check("stall", stall, r && haz);
        check("EN", EN, e_en);
        check("rs_addr", rs_addr, ins[25:21]);
        check("rt_addr", rt_addr, ins[20:16]);
        s_sel = select; s_stall = stall; s_en = EN;
        @(posedge clock1);
        if (!r) model_reset();
        else if (m_sq || haz) begin
            model_reset_word();
            m_sq = 0;
        end else begin
            m_sq = e_sel;
            m_ill = m_ill || (cur && !known(op));
            m_valid = cur; m_op = op; m_rs = ins[25:21]; m_rt = ins[20:16];
            m_dest = dest_of(ins);
            m_imm = {{16{ins[15]}}, ins[15:0]};
            m_npc = npc; m_wr = writes(op);
            m_rd = op == OP_LD; m_wm = op == OP_ST;
        end
        #1;
        check("id_valid", id_valid, m_valid);
        check("id_opcode", id_opcode, m_op);
        check("id_rs", id_rs, m_rs);
        check("id_rt", id_rt, m_rt);
        check("id_dest", id_dest, m_dest);
        check("id_imm", id_imm, m_imm);
        check("id_npc", id_npc, m_npc);
        check("id_wr_en", id_wr_en, m_wr);
        check("id_mem_rd", id_mem_rd, m_rd);
        check("id_mem_wr", id_mem_wr, m_wm);
        check("illegal", illegal, m_ill);
    endtask

    task automatic model_reset_word();
        m_valid = 0; m_wr = 0; m_rd = 0; m_wm = 0;
        m_op = 0; m_rs = 0; m_rt = 0; m_dest = 0; m_imm = 0; m_npc = 0;
    endtask

    initial begin
        logic [31:0] ins, rsd;
        logic [7:0]  npc;
        logic        v, r;
        logic [5:0]  op;
        int          k;
        model_reset();
        repeat (3) step(mk(OP_BR, 0, 0, 16'h0020), 8'h01, 1, 0, 0);
        check("rst_sel", s_sel, 0);
        check("rst_stall", s_stall, 0);
        check("rst_valid", id_valid, 0);
        check("rst_illegal", illegal, 0);
        step(mk(OP_BR, 0, 0, 16'h0020), 8'h01, 1, 0, 1);
        check("br_sel", s_sel, 1);
        check("br_en", s_en, 8'h20);
        step(mk(OP_ALU, 1, 2, 16'h1800), 8'h02, 1, 9, 1);
        check("br_squash", id_valid, 0);
        step(mk(OP_BZ, 2, 0, 16'h0040), 8'h05, 1, 0, 1);
        check("bz_sel", s_sel, 1);
        check("bz_en", s_en, 8'h40);
        step(mk(OP_ADDI, 1, 6, 16'h0001), 8'h06, 1, 5, 1);
        check("bz_squash", id_valid, 0);
        step(mk(OP_ADDI, 1, 6, 16'h0001), 8'h41, 1, 5, 1);
        check("resume", id_valid, 1);
        step(mk(OP_BNZ, 1, 0, 16'h0010), 8'h33, 1, 0, 1);
        check("bnz_sel", s_sel, 0);
        check("bnz_en", s_en, 0);
        check("bnz_npc", id_npc, 8'h33);
        step(mk(OP_LD, 1, 3, 16'h0004), 8'h34, 1, 1, 1);
        step(mk(OP_ALU, 3, 2, 16'h2800), 8'h35, 1, 1, 1);
        check("lu_stall", s_stall, 1);
        check("lu_bubble", id_valid, 0);
        step(mk(OP_ALU, 3, 2, 16'h2800), 8'h35, 1, 1, 1);
        check("lu_go", s_stall, 0);
        check("lu_dest", id_dest, 5);
        step(mk(OP_ADDI, 1, 4, 16'h0007), 8'h36, 1, 1, 1);
        step(mk(OP_BNZ, 4, 0, 16'h0050), 8'h37, 1, 0, 1);
        check("bd_stall", s_stall, 1);
        step(mk(OP_BNZ, 4, 0, 16'h0050), 8'h37, 1, 7, 1);
        check("bd_go", s_stall, 0);
        check("bd_en", s_en, 8'h50);
        step(mk(OP_ALU, 1, 2, 16'h2000), 8'h38, 1, 1, 1);
        step(mk(OP_ALU, 1, 2, 16'h2000), 8'h51, 1, 1, 1);
        step(mk(OP_ALU, 4, 4, 16'h3800), 8'h52, 1, 1, 1);
        check("alu_fwd", s_stall, 0);
        step(mk(OP_BR, 0, 0, 16'h00FF), 8'h53, 1, 0, 1);
        check("en_ff", s_en, 8'hFF);
        step(mk(OP_ALU, 0, 0, 16'h0000), 8'h54, 1, 0, 1);
        step(mk(OP_CALL, 0, 0, 16'h0080), 8'h11, 1, 0, 1);
        check("call_sel", s_sel, 1);
        check("call_en", s_en, 8'h80);
        check("call_dest", id_dest, 31);
        check("call_wr", id_wr_en, 1);
        check("call_npc", id_npc, 8'h11);
        step(mk(OP_ALU, 0, 0, 16'h0000), 8'h12, 1, 0, 1);
        step(mk(6'h3F, 0, 0, 16'h0000), 8'h81, 1, 0, 1);
        check("ill_set", illegal, 1);
        check("ill_nop", id_wr_en, 0);
        repeat (2) step(mk(OP_ALU, 1, 1, 16'h0800), 8'h82, 1, 0, 1);
        check("ill_sticky", illegal, 1);
        step(mk(OP_ALU, 1, 1, 16'h0800), 8'h83, 1, 0, 0);
        check("ill_clear", illegal, 0);

        ins = 0; npc = 0; v = 1;
        for (int i = 0; i < 3000; i++) begin
            if (!s_stall || !rst) begin
                k = $urandom_range(0, 10);
                op = (k <= 8) ? 6'(k) : 6'($urandom_range(9, 63));
                ins = mk(op, 5'($urandom_range(0, 7)),
                         5'($urandom_range(0, 7)), 16'($urandom));
                npc = 8'($urandom);
                v = ($urandom_range(0, 7) != 0);
            end
            rsd = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
            r = ($urandom_range(0, 63) != 0);
            step(ins, npc, v, rsd, r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
